// File: rtl/ahb_burst_master.sv
// Command-driven AHB-lite burst master: one command at a time, address phase of
// beat n+1 overlapped with the data phase of beat n, BUSY inserted on late write data.
module ahb_burst_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 5
) (
   input  logic              Hclk,
   input  logic              Hresetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_burst,
   input  logic [2:0]        cmd_size,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              done,
   input  logic              Hreadyout,
   input  logic [DATA_W-1:0] Hrdata,
   output logic [ADDR_W-1:0] Haddr,
   output logic [DATA_W-1:0] Hwdata,
   output logic              Hwrite,
   output logic              Hreadyin,
   output logic [1:0]        Htrans,
   output logic [2:0]        Hsize,
   output logic [2:0]        Hburst
);
   // state   | meaning
   // S_IDLE  | no command, cmd_ready high
   // S_ADDR  | NONSEQ/SEQ address phase on the bus
   // S_BUSYW | waiting for write data (BUSY mid-burst, IDLE before first beat)
   // S_LAST  | data phase of the final beat, Htrans IDLE

   localparam int CNT_W    = (LEN_W > 5) ? LEN_W : 5;
   localparam int MAX_SIZE = $clog2(DATA_W / 8);

   localparam logic [1:0] HT_IDLE   = 2'd0;
   localparam logic [1:0] HT_BUSY   = 2'd1;
   localparam logic [1:0] HT_NONSEQ = 2'd2;
   localparam logic [1:0] HT_SEQ    = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BUSYW, S_LAST} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   logic              first_q, first_nxt;
   logic [DATA_W-1:0] wbuf_q, wbuf_nxt;
   logic              dphase_q;

   logic [ADDR_W-1:0] haddr_nxt, hwdata_nxt_a, inc, mask, next_addr;
   logic [DATA_W-1:0] hwdata_nxt;
   logic [1:0]        htrans_nxt;
   logic              hwrite_nxt;
   logic [2:0]        hsize_nxt, hburst_nxt, size_c, wrap_sh;
   logic [CNT_W-1:0]  beats_c;

   assign Hreadyin = Hreadyout;

   always_comb begin
      size_c  = (cmd_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : cmd_size;
      beats_c = CNT_W'(1);
      case (cmd_burst)
         3'd1:       beats_c = (cmd_len == '0) ? CNT_W'(1) : CNT_W'(cmd_len);
         3'd2, 3'd3: beats_c = CNT_W'(4);
         3'd4, 3'd5: beats_c = CNT_W'(8);
         3'd6, 3'd7: beats_c = CNT_W'(16);
         default:    beats_c = CNT_W'(1);
      endcase
   end

   // Even non-zero Hburst codes are WRAP4/8/16; the wrap window is beats*inc bytes.
   always_comb begin
      inc     = ADDR_W'(1) << Hsize;
      wrap_sh = {1'b0, Hburst[2:1]} + 3'd1;
      mask    = (inc << wrap_sh) - ADDR_W'(1);
      hwdata_nxt_a = Haddr + inc;
      if (Hburst != 3'd0 && !Hburst[0])
         next_addr = (Haddr & ~mask) | (hwdata_nxt_a & mask);
      else
         next_addr = hwdata_nxt_a;
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt_q;
      first_nxt  = first_q;
      wbuf_nxt   = wbuf_q;
      haddr_nxt  = Haddr;
      hwdata_nxt = Hwdata;
      htrans_nxt = Htrans;
      hwrite_nxt = Hwrite;
      hsize_nxt  = Hsize;
      hburst_nxt = Hburst;
      wr_ready   = 1'b0;
      cmd_ready  = 1'b0;

      if (Htrans[1] && Hreadyout && Hwrite)
         hwdata_nxt = wbuf_q;

      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               haddr_nxt  = cmd_addr;
               hwrite_nxt = cmd_write;
               hsize_nxt  = size_c;
               hburst_nxt = cmd_burst;
               cnt_nxt    = beats_c;
               state_nxt  = S_ADDR;
               htrans_nxt = HT_NONSEQ;
               if (cmd_write) begin
                  wr_ready = 1'b1;
                  if (wr_valid) begin
                     wbuf_nxt = wr_data;
                  end else begin
                     state_nxt  = S_BUSYW;
                     htrans_nxt = HT_IDLE;
                     first_nxt  = 1'b1;
                  end
               end
            end
         end
         S_ADDR: begin
            if (Hreadyout) begin
               if (cnt_q == CNT_W'(1)) begin
                  state_nxt  = S_LAST;
                  htrans_nxt = HT_IDLE;
               end else begin
                  cnt_nxt    = cnt_q - CNT_W'(1);
                  haddr_nxt  = next_addr;
                  htrans_nxt = HT_SEQ;
                  if (Hwrite) begin
                     wr_ready = 1'b1;
                     if (wr_valid) begin
                        wbuf_nxt = wr_data;
                     end else begin
                        state_nxt  = S_BUSYW;
                        htrans_nxt = HT_BUSY;
                        first_nxt  = 1'b0;
                     end
                  end
               end
            end
         end
         S_BUSYW: begin
            // Before the first beat there is no data phase to stall on.
            wr_ready = first_q | Hreadyout;
            if (wr_ready && wr_valid) begin
               wbuf_nxt   = wr_data;
               state_nxt  = S_ADDR;
               htrans_nxt = first_q ? HT_NONSEQ : HT_SEQ;
               first_nxt  = 1'b0;
            end
         end
         S_LAST: begin
            if (Hreadyout)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state    <= S_IDLE;
         cnt_q    <= '0;
         first_q  <= 1'b0;
         wbuf_q   <= '0;
         dphase_q <= 1'b0;
         Haddr    <= '0;
         Hwdata   <= '0;
         Htrans   <= HT_IDLE;
         Hwrite   <= 1'b0;
         Hsize    <= 3'd0;
         Hburst   <= 3'd0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt_q    <= cnt_nxt;
         first_q  <= first_nxt;
         wbuf_q   <= wbuf_nxt;
         Haddr    <= haddr_nxt;
         Hwdata   <= hwdata_nxt;
         Htrans   <= htrans_nxt;
         Hwrite   <= hwrite_nxt;
         Hsize    <= hsize_nxt;
         Hburst   <= hburst_nxt;
         if (Hreadyout)
            dphase_q <= Htrans[1];
         rd_valid <= Hreadyout & dphase_q & ~Hwrite;
         if (Hreadyout && dphase_q && !Hwrite)
            rd_data <= Hrdata;
         done     <= (state == S_LAST) & Hreadyout;
      end
   end
endmodule

// File: doc/ahb_burst_master.md
# ahb_burst_master

Parametrised, synthesizable AHB-lite master engine that replaces task-driven stimulus with a command-driven transfer sequencer. It accepts one transfer command at a time (single, INCR, INCR4/8/16, WRAP4/8/16) and sequences the address and data phases on the AHB side toward the AHB-to-APB bridge. The address phase of beat n+1 is pipelined against the data phase of beat n. It honours slave wait states (Hreadyout), inserts BUSY when write data is late, and returns read data beat by beat.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (32 or 64)
- LEN_W, 5, width of cmd_len (undefined-length INCR beat count)

- Hclk  in  1  clock, all state on rising edge
- Hresetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle, command accepted when both high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  start address
- cmd_burst  in  3  Hburst encoding (0 SINGLE, 1 INCR, 2/3 WRAP4/INCR4, 4/5 WRAP8/INCR8, 6/7 WRAP16/INCR16)
- cmd_size  in  3  Hsize encoding
- cmd_len  in  LEN_W  beat count for INCR only; 0 treated as 1
- wr_data  in  DATA_W  next write beat
- wr_valid  in  1  wr_data available
- wr_ready  out  1  beat consumed when wr_valid & wr_ready
- rd_data  out  DATA_W  captured Hrdata
- rd_valid  out  1  one-cycle pulse per completed read beat
- done  out  1  one-cycle pulse when the last data phase completes
- Hreadyout  in  1  slave ready
- Hrdata  in  DATA_W  slave read data
- Haddr  out  ADDR_W  address
- Hwdata  out  DATA_W  write data
- Hwrite  out  1  direction
- Hreadyin  out  1  equals Hreadyout (combinational feed-through)
- Htrans  out  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- Hsize  out  3  transfer size
- Hburst  out  3  burst type

## Operation
- States: IDLE, ADDR (NONSEQ or SEQ on bus), BUSYW (BUSY, waiting for write data), LAST (data phase of final beat, Htrans=IDLE).
- IDLE: cmd_ready=1. Command accepted -> latch all fields; beats = 1/4/8/16 by burst, or max(cmd_len,1) for INCR. For reads go to ADDR; for writes go to ADDR only once wr_valid (first beat consumed at NONSEQ issue).
- Write beat consumed (wr_ready=1) in the cycle its address phase is issued; data registered into Hwdata for the following data phase.
- Beat accepted at a rising edge with Htrans in {NONSEQ,SEQ} and Hreadyout=1. Then: more beats left -> next address, Htrans=SEQ (write with wr_valid=0 -> BUSYW, Htrans=BUSY, Haddr already the next address); no beats left -> LAST.
- BUSYW -> ADDR (SEQ) on wr_valid.
- LAST: leave on Hreadyout=1 -> IDLE, done pulses.
- Hreadyout=0: Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata hold; no beat counted.
- Address increment inc = 1<<Hsize. INCR: Haddr+inc. WRAPn: mask = n*inc-1; next = (Haddr & ~mask) | ((Haddr+inc) & mask). Address arithmetic is modulo 2^ADDR_W. cmd_size above log2(DATA_W/8) is clamped to that maximum.
- No 1 KB boundary splitting; no HRESP handling.

## Timing
- Reset: Haddr=0, Hwdata=0, Hwrite=0, Htrans=IDLE, Hsize=0, Hburst=0, rd_data=0, rd_valid=0, done=0, wr_ready=0, cmd_ready=1, state IDLE. Reset mid-burst aborts immediately; no rd_valid/done issued.
- Command accepted at edge T -> NONSEQ on bus in cycle T+1 (write: first cycle after T with wr_valid).
- Zero-wait N-beat burst: N address cycles + 1 LAST cycle; done pulses in the cycle after the final data-phase edge.
- rd_valid/rd_data registered: asserted the cycle after each read data-phase edge with Hreadyout=1.
- cmd_ready low from acceptance until the cycle done pulses; back-to-back commands separated by one IDLE cycle.

## Test plan
- Single write 0x80000001 size 0, data 0x80, Hreadyout=1 -> NONSEQ 1 cycle, Hwdata=0x80 next cycle, done 2 cycles after NONSEQ.
- Single read 0x80000001, Hreadyout low 2 cycles in data phase, Hrdata=0x5A -> controls held, one rd_valid with rd_data=0x5A.
- INCR4 write from 0x80000000 size 2 -> Haddr 0x00,0x04,0x08,0x0C (upper 0x8000), NONSEQ,SEQ,SEQ,SEQ, four wr_ready pulses.
- WRAP4 read from 0x8000000C size 2 -> Haddr 0x0C,0x00,0x04,0x08, four rd_valid pulses.
- INCR4 write with wr_valid low before beat 3 for 2 cycles -> Htrans=BUSY 2 cycles with Haddr=beat-3 address, then SEQ resumes.
- Hresetn low during beat 2 of INCR8 -> all outputs at reset values asynchronously, cmd_ready=1, no done.
